// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: owns the PC, fetches one word at a time over a
// req/ready handshake, holds it for the decoder and picks the next PC on commit.
module ifetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        instr_valid,
  input  logic        commit,
  input  logic [1:0]  pc_sel,
  input  logic [1:0]  is_jump,
  input  logic        br_taken,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        fault
);

  // Counter only has to hold 0..MAX_WAIT-1; the last empty cycle faults instead.
  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] WaitLast = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StFetch, StIssue, StFault} state_e;

  state_e        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   instr_q;
  logic [31:0]   retired_q;
  logic          instr_valid_q;
  logic          fault_q;
  logic [CW-1:0] wait_cnt_q;

  logic [31:0]   br_off;
  logic [31:0]   next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect selection, priority jr > j/jal > taken branch > sequential.
  always_comb begin
    br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    next_pc = pc_plus4;
    if (is_jump == 2'b10) begin
      next_pc = jr_target;
    end else if (is_jump == 2'b01) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (pc_sel == 2'b01 && br_taken) begin
      next_pc = pc_plus4 + br_off;
    end
  end

  // Fetch FSM with registered instr, valid, retire count and sticky fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      retired_q     <= 32'd0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_ready) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            wait_cnt_q    <= '0;
            state_q       <= StIssue;
          end else if (wait_cnt_q == WaitLast) begin
            fault_q <= 1'b1;
            state_q <= StFault;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StIssue: begin
          if (commit) begin
            retired_q     <= retired_q + 32'd1;
            instr_valid_q <= 1'b0;
            if (next_pc[1:0] == 2'b00) begin
              pc_q    <= next_pc;
              state_q <= StFetch;
            end else begin
              fault_q <= 1'b1;
              state_q <= StFault;
            end
          end
        end
        StFault: begin
          instr_valid_q <= 1'b0;
          fault_q       <= 1'b1;
        end
        default: begin
          instr_valid_q <= 1'b0;
          fault_q       <= 1'b1;
          state_q       <= StFault;
        end
      endcase
    end
  end

  // Request drops combinationally with rst so no fetch is issued while in reset.
  assign imem_req    = (state_q == StFetch) && !rst;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign func        = instr_q[5:0];
  assign instr_valid = instr_valid_q;
  assign retired     = retired_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ifetch_seq.sv
// Self-checking bench for ifetch_seq against a next-PC reference model.
module tb_ifetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        instr_valid;
  logic        commit;
  logic [1:0]  pc_sel;
  logic [1:0]  is_jump;
  logic        br_taken;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;
  logic        fault;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_retired;
  logic        m_fault;

  ifetch_seq #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .func(func), .instr_valid(instr_valid), .commit(commit), .pc_sel(pc_sel),
    .is_jump(is_jump), .br_taken(br_taken), .jr_target(jr_target), .pc(pc),
    .pc_plus4(pc_plus4), .retired(retired), .fault(fault)
  );

  always #5 clk = ~clk;

  // Next PC from the instruction-set rules, using plain integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic [1:0] ps, input logic [1:0] ij,
                                           input logic bt, input logic [31:0] jt);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(ins[15:0]));
    if (ij == 2'b10) return jt;
    if (ij == 2'b01) return (seq & 32'hF000_0000) | ({6'd0, ins[25:0]} << 2);
    if (ps == 2'b01 && bt) return seq + 32'(off * 4);
    return seq;
  endfunction

  // Stimulus: reset pulse, leaves the bench at a falling edge with rst released.
  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    commit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_retired = 32'h0; m_fault = 1'b0;
    #1;
  endtask

  // Stimulus: answer the current fetch after 'delay' empty cycles.
  task automatic serve(input logic [31:0] word, input int unsigned delay);
    for (int i = 0; i < int'(delay); i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    m_instr    = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
  endtask

  // Stimulus: one-cycle commit pulse with redirect inputs; advances the model.
  task automatic do_commit(input logic [1:0] ps, input logic [1:0] ij, input logic bt,
                           input logic [31:0] jt);
    logic [31:0] nxt;
    commit = 1'b1; pc_sel = ps; is_jump = ij; br_taken = bt; jr_target = jt;
    nxt = ref_next(m_pc, m_instr, ps, ij, bt, jt);
    @(negedge clk);
    commit = 1'b0; pc_sel = 2'($urandom); is_jump = 2'($urandom);
    br_taken = 1'($urandom); jr_target = $urandom;
    m_retired = m_retired + 32'd1;
    if (nxt[1:0] != 2'b00) m_fault = 1'b1;
    else m_pc = nxt;
  endtask

  // Stimulus: move the PC to an aligned address via a jr.
  task automatic goto(input logic [31:0] addr);
    serve(32'h0000_0000, 0);
    do_commit(2'b00, 2'b10, 1'b0, addr);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    commit = 1'b1; pc_sel = 2'b00; is_jump = 2'b00; br_taken = 1'b0; jr_target = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc); end
    checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rst_instr got %h/%b exp 0/0", instr, instr_valid); end
    checks++; if (retired !== 32'h0 || fault !== 1'b0) begin
      errors++; $display("FAIL rst_cnt got %h/%b exp 0/0", retired, fault); end
    imem_ready = 1'b0; commit = 1'b0;
    rst = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_retired = 32'h0; m_fault = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_release_req got %b exp 1", imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] w;
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem_addr !== 32'(4 * k)) begin
        errors++; $display("FAIL seq_addr got %h exp %h", imem_addr, 32'(4 * k)); end
      w = {6'd0, 20'($urandom), 6'($urandom)};
      serve(w, 0);
      checks++; if (instr_valid !== 1'b1 || instr !== w) begin
        errors++; $display("FAIL seq_instr got %b/%h exp 1/%h", instr_valid, instr, w); end
      checks++; if (opcode !== w[31:26] || func !== w[5:0]) begin
        errors++; $display("FAIL seq_decode got %h/%h exp %h/%h", opcode, func, w[31:26], w[5:0]); end
      do_commit(2'b00, 2'b00, 1'($urandom), $urandom);
      checks++; if (retired !== 32'(k + 1) || instr_valid !== 1'b0) begin
        errors++; $display("FAIL seq_retired got %0d/%b exp %0d/0", retired, instr_valid, k + 1); end
    end
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL seq_addr3 got %h exp c", imem_addr); end
  endtask

  task automatic test_branch();
    logic [31:0] beq;
    beq = {6'h04, 5'd1, 5'd2, 16'hFFFC};
    goto(32'h10);
    serve(beq, 0);
    do_commit(2'b01, 2'b00, 1'b1, 32'h0);
    checks++; if (imem_addr !== 32'h04 || imem_addr !== m_pc) begin
      errors++; $display("FAIL beq_taken got %h exp 00000004", imem_addr); end
    goto(32'h10);
    serve(beq, 1);
    do_commit(2'b01, 2'b00, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL beq_not_taken got %h exp 00000014", imem_addr); end
  endtask

  task automatic test_jump();
    goto(32'h3000_0008);
    serve({6'h02, 26'h0000100}, 0);
    do_commit(2'b01, 2'b01, 1'b1, 32'h0);
    checks++; if (imem_addr !== 32'h3000_0400) begin
      errors++; $display("FAIL j_target got %h exp 30000400", imem_addr); end
    serve({6'h00, 5'd4, 15'd0, 6'h08}, 2);
    do_commit(2'b01, 2'b10, 1'b1, 32'h40);
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL jr_target got %h exp 00000040", imem_addr); end
  endtask

  task automatic test_wrap();
    goto(32'hFFFF_FFFC);
    serve(32'h0, 0);
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp 0", pc_plus4); end
    do_commit(2'b00, 2'b00, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_seq got %h exp 0", imem_addr); end
    serve({6'h05, 10'd0, 16'hFFFE}, 0);
    do_commit(2'b01, 2'b00, 1'b1, 32'h0);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_branch got %h exp fffffffc", imem_addr); end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    logic [31:0] hold_pc;
    w = $urandom;
    hold_pc = m_pc;
    serve(w, 0);
    for (int i = 0; i < 10; i++) begin
      imem_ready = 1'b1; imem_rdata = ~w;
      @(negedge clk);
      checks++; if (instr !== w || opcode !== w[31:26] || pc !== hold_pc) begin
        errors++; $display("FAIL stall_hold cyc %0d got %h/%h exp %h/%h", i, instr, pc, w, hold_pc); end
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        errors++; $display("FAIL stall_req cyc %0d got req %b valid %b exp 0/1", i, imem_req, instr_valid); end
    end
    imem_ready = 1'b0;
    do_commit(2'b00, 2'b00, 1'b0, 32'h0);
    checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL stall_next got %h exp %h", imem_addr, m_pc); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [1:0]  ps, ij;
    for (int n = 0; n < 40; n++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
        errors++; $display("FAIL rnd_addr %0d got %b/%h exp 1/%h", n, imem_req, imem_addr, m_pc); end
      w = $urandom;
      serve(w, $urandom_range(0, 3));
      checks++; if (instr !== w || pc_plus4 !== m_pc + 32'd4 || instr_valid !== 1'b1) begin
        errors++; $display("FAIL rnd_issue %0d got %h/%h exp %h/%h", n, instr, pc_plus4, w, m_pc + 32'd4); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ps = 2'($urandom); ij = 2'($urandom);
      do_commit(ps, ij, 1'($urandom), $urandom & 32'hFFFF_FFFC);
      checks++; if (retired !== m_retired || fault !== 1'b0) begin
        errors++; $display("FAIL rnd_retired %0d got %0d/%b exp %0d/0", n, retired, fault, m_retired); end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] jr_pc;
    goto(32'h0000_0100);
    jr_pc = m_pc;
    serve({6'h00, 5'd4, 15'd0, 6'h08}, 0);
    do_commit(2'b00, 2'b10, 1'b0, 32'h42);
    checks++; if (fault !== m_fault || fault !== 1'b1) begin
      errors++; $display("FAIL misalign_fault got %b exp 1", fault); end
    checks++; if (pc !== jr_pc || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL misalign_hold got pc %h req %b valid %b exp %h/0/0", pc, imem_req, instr_valid, jr_pc); end
    for (int i = 0; i < 3; i++) begin
      commit = 1'b1; imem_ready = 1'b1; is_jump = 2'b00;
      @(negedge clk);
      checks++; if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== jr_pc || retired !== m_retired) begin
        errors++; $display("FAIL fault_sticky cyc %0d got f %b req %b pc %h ret %0d", i, fault, imem_req, pc, retired); end
    end
    do_reset();
    checks++; if (fault !== 1'b0 || pc !== 32'h0) begin
      errors++; $display("FAIL misalign_reset got %b/%h exp 0/0", fault, pc); end
  endtask

  task automatic test_timeout();
    imem_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (fault !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL timeout_early got f %b req %b exp 0/1", fault, imem_req); end
    @(negedge clk);
    checks++; if (fault !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_fault got f %b req %b exp 1/0", fault, imem_req); end
    do_reset();
    checks++; if (fault !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL timeout_reset got %b/%h/%b exp 0/0/1", fault, pc, imem_req); end
  endtask

  task automatic test_rst_midfetch();
    logic [31:0] w;
    goto(32'h0000_0200);
    imem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || pc !== 32'h0) begin
      errors++; $display("FAIL midfetch_rst got req %b pc %h exp 0/0", imem_req, pc); end
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_ready = 1'b0;
    rst = 1'b0;
    m_pc = 32'h0; m_retired = 32'h0; m_fault = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || retired !== 32'h0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL midfetch_release got v %b ret %0d addr %h", instr_valid, retired, imem_addr); end
    w = $urandom;
    serve(w, 1);
    checks++; if (instr !== w) begin errors++; $display("FAIL midfetch_fresh got %h exp %h", instr, w); end
    do_commit(2'b00, 2'b00, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; commit = 1'b0;
    pc_sel = 2'b00; is_jump = 2'b00; br_taken = 1'b0; jr_target = 32'h0;
    m_pc = 32'h0; m_instr = 32'h0; m_retired = 32'h0; m_fault = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap();
    test_stall();
    test_random();
    test_misalign();
    test_timeout();
    test_rst_midfetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
